cpu64_l1_line_engine: RTL and testbench

- Miss-service stage directly upstream of the L1 data/tag/valid/dirty arrays (32KiB, 8-way, 64 sets, 64B lines, 8×64b words).
- On a request from the L1 controller, optionally writes back a dirty victim line to memory by reading the arrays word by word.
- Then fetches the new line as an 8-beat burst and writes each beat into the arrays, installing the tag and marking the line clean.
- It is the only writer of the array write port while busy.

---
 rtl/cpu64_l1_line_engine.sv | 166 ++++++++++++++++
 tb/tb_cpu64_l1_line_engine.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu64_l1_line_engine.sv
// L1 miss-service engine: optional dirty-victim writeback, then an 8-beat refill
// written straight into the L1 data/tag/valid/dirty arrays.
module cpu64_l1_line_engine #(
  parameter int BEATS = 8,
  parameter int TAG_W = 52
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [63:0]      req_addr_i,
  input  logic [2:0]       req_way_i,
  input  logic             req_wb_i,
  input  logic [TAG_W-1:0] req_victim_tag_i,
  output logic [5:0]       arr_index_o,
  output logic [2:0]       arr_word_sel_o,
  output logic [2:0]       arr_way_sel_o,
  output logic             arr_write_en_o,
  output logic             arr_set_valid_o,
  output logic             arr_set_dirty_o,
  output logic [7:0]       arr_be_o,
  output logic [TAG_W-1:0] arr_tag_o,
  output logic [63:0]      arr_wdata_o,
  input  logic [63:0]      arr_rdata_i,
  output logic             mem_wr_valid_o,
  input  logic             mem_wr_ready_i,
  output logic [63:0]      mem_wr_addr_o,
  output logic [63:0]      mem_wr_data_o,
  output logic             mem_wr_last_o,
  output logic             mem_rd_req_valid_o,
  input  logic             mem_rd_req_ready_i,
  output logic [63:0]      mem_rd_addr_o,
  input  logic             mem_rd_valid_i,
  input  logic [63:0]      mem_rd_data_i,
  input  logic             mem_rd_last_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             proto_err_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_DATA = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [63:6]      addr_q, addr_d;
  logic [2:0]       way_q, way_d;
  logic [TAG_W-1:0] vtag_q, vtag_d;
  logic             last_word;
  logic             beat;

  // Line offset bits never matter to a whole-line engine.
  logic unused_offset;
  assign unused_offset = ^req_addr_i[5:0];

  assign last_word = (cnt_q == 3'(BEATS - 1));
  // A beat coinciding with reset must not reach the arrays.
  assign beat      = (state_q == S_RD_DATA) && mem_rd_valid_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      way_q   <= '0;
      vtag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
      vtag_q  <= vtag_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    addr_d             = addr_q;
    way_d              = way_q;
    vtag_d             = vtag_q;
    req_ready_o        = 1'b0;
    arr_index_o        = '0;
    arr_word_sel_o     = '0;
    arr_way_sel_o      = '0;
    arr_write_en_o     = 1'b0;
    arr_set_valid_o    = 1'b0;
    arr_set_dirty_o    = 1'b0;
    arr_be_o           = '0;
    arr_tag_o          = '0;
    arr_wdata_o        = '0;
    mem_wr_valid_o     = 1'b0;
    mem_wr_addr_o      = '0;
    mem_wr_data_o      = '0;
    mem_wr_last_o      = 1'b0;
    mem_rd_req_valid_o = 1'b0;
    mem_rd_addr_o      = '0;
    busy_o             = (state_q != S_IDLE);
    done_o             = 1'b0;
    proto_err_o        = 1'b0;

    if (state_q != S_IDLE) begin
      arr_index_o    = addr_q[11:6];
      arr_way_sel_o  = way_q;
      arr_word_sel_o = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i[63:6];
          way_d   = req_way_i;
          vtag_d  = req_victim_tag_i;
          cnt_d   = '0;
          state_d = req_wb_i ? S_WB : S_RD_REQ;
        end
      end
      S_WB: begin
        mem_wr_valid_o = 1'b1;
        mem_wr_addr_o  = {vtag_q, addr_q[11:6], 6'b0};
        mem_wr_data_o  = arr_rdata_i;
        mem_wr_last_o  = last_word;
        if (mem_wr_ready_i) begin
          cnt_d = cnt_q + 3'd1;
          if (last_word) begin
            cnt_d   = '0;
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        mem_rd_req_valid_o = 1'b1;
        mem_rd_addr_o      = {addr_q, 6'b0};
        if (mem_rd_req_ready_i) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (beat) begin
          arr_write_en_o  = 1'b1;
          arr_be_o        = 8'hFF;
          arr_wdata_o     = mem_rd_data_i;
          arr_tag_o       = addr_q[63:64-TAG_W];
          arr_set_valid_o = last_word;
          // The word counter, not the last marker, decides completion.
          proto_err_o     = (mem_rd_last_i != last_word);
          cnt_d           = cnt_q + 3'd1;
          if (last_word) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu64_l1_line_engine.sv
// Bench for cpu64_l1_line_engine: a behavioural array/memory model checked with
// immediate assertions over directed and randomized miss-service transactions.
module tb_cpu64_l1_line_engine;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic [2:0]  req_way_i;
  logic        req_wb_i;
  logic [51:0] req_victim_tag_i;
  logic [5:0]  arr_index_o;
  logic [2:0]  arr_word_sel_o;
  logic [2:0]  arr_way_sel_o;
  logic        arr_write_en_o;
  logic        arr_set_valid_o;
  logic        arr_set_dirty_o;
  logic [7:0]  arr_be_o;
  logic [51:0] arr_tag_o;
  logic [63:0] arr_wdata_o;
  logic [63:0] arr_rdata_i;
  logic        mem_wr_valid_o;
  logic        mem_wr_ready_i;
  logic [63:0] mem_wr_addr_o;
  logic [63:0] mem_wr_data_o;
  logic        mem_wr_last_o;
  logic        mem_rd_req_valid_o;
  logic        mem_rd_req_ready_i;
  logic [63:0] mem_rd_addr_o;
  logic        mem_rd_valid_i;
  logic [63:0] mem_rd_data_i;
  logic        mem_rd_last_i;
  logic        busy_o;
  logic        done_o;
  logic        proto_err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu64_l1_line_engine dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_way_i(req_way_i), .req_wb_i(req_wb_i), .req_victim_tag_i(req_victim_tag_i),
    .arr_index_o(arr_index_o), .arr_word_sel_o(arr_word_sel_o), .arr_way_sel_o(arr_way_sel_o),
    .arr_write_en_o(arr_write_en_o), .arr_set_valid_o(arr_set_valid_o),
    .arr_set_dirty_o(arr_set_dirty_o), .arr_be_o(arr_be_o), .arr_tag_o(arr_tag_o),
    .arr_wdata_o(arr_wdata_o), .arr_rdata_i(arr_rdata_i),
    .mem_wr_valid_o(mem_wr_valid_o), .mem_wr_ready_i(mem_wr_ready_i),
    .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o), .mem_wr_last_o(mem_wr_last_o),
    .mem_rd_req_valid_o(mem_rd_req_valid_o), .mem_rd_req_ready_i(mem_rd_req_ready_i),
    .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_valid_i(mem_rd_valid_i),
    .mem_rd_data_i(mem_rd_data_i), .mem_rd_last_i(mem_rd_last_i),
    .busy_o(busy_o), .done_o(done_o), .proto_err_o(proto_err_o)
  );

  // Behavioural L1 arrays: written only through the engine's strobe or a preload port.
  logic [63:0] arr_data  [64][8][8];
  logic        arr_valid [64][8];
  logic [51:0] arr_tag   [64][8];
  int          wr_cnt   = 0;
  int          vset_cnt = 0;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx;
  logic [2:0]  pl_way, pl_word;
  logic [63:0] pl_data;

  assign arr_rdata_i = arr_data[arr_index_o][arr_way_sel_o][arr_word_sel_o];

  always @(posedge clk) begin
    if (arr_write_en_o) begin
      arr_data[arr_index_o][arr_way_sel_o][arr_word_sel_o] <= arr_wdata_o;
      arr_valid[arr_index_o][arr_way_sel_o] <= arr_set_valid_o;
      arr_tag[arr_index_o][arr_way_sel_o]   <= arr_tag_o;
      wr_cnt <= wr_cnt + 1;
      if (arr_set_valid_o) vset_cnt <= vset_cnt + 1;
    end else if (pl_en) begin
      arr_data[pl_idx][pl_way][pl_word] <= pl_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string ctx);
    chk({ctx, "_ready"}, 64'(req_ready_o), 64'd1);
    chk({ctx, "_busy"}, 64'(busy_o), 64'd0);
    chk({ctx, "_done"}, 64'(done_o), 64'd0);
    chk({ctx, "_perr"}, 64'(proto_err_o), 64'd0);
    chk({ctx, "_awe"}, 64'(arr_write_en_o), 64'd0);
    chk({ctx, "_aidx"}, {arr_index_o, arr_way_sel_o, arr_word_sel_o, arr_be_o}, 64'd0);
    chk({ctx, "_atag"}, {12'd0, arr_tag_o}, 64'd0);
    chk({ctx, "_awd"}, arr_wdata_o, 64'd0);
    chk({ctx, "_wrv"}, {mem_wr_valid_o, mem_wr_last_o, mem_rd_req_valid_o, arr_set_valid_o}, 64'd0);
    chk({ctx, "_wra"}, mem_wr_addr_o | mem_wr_data_o, 64'd0);
    chk({ctx, "_rda"}, mem_rd_addr_o, 64'd0);
  endtask

  task automatic do_req(input logic [63:0] addr, input logic [2:0] way, input logic wb,
                        input logic [51:0] vtag);
    req_valid_i = 1'b1; req_addr_i = addr; req_way_i = way; req_wb_i = wb; req_victim_tag_i = vtag;
    @(negedge clk);
    chk("req_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  // Victim words are snapshotted from the model before the engine touches anything.
  task automatic wb_phase(input logic [63:0] addr, input logic [2:0] way, input logic [51:0] vtag,
                          input int ready_pct);
    logic [63:0] exp_w [8];
    int k = 0;
    int cyc = 0;
    logic hs;
    for (int w = 0; w < 8; w++) exp_w[w] = arr_data[addr[11:6]][way][w];
    while (k < 8 && cyc < 300) begin
      mem_wr_ready_i = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      chk("wb_valid", 64'(mem_wr_valid_o), 64'd1);
      chk("wb_addr", mem_wr_addr_o, {vtag, addr[11:6], 6'b0});
      chk("wb_data", mem_wr_data_o, exp_w[k]);
      chk("wb_last", 64'(mem_wr_last_o), 64'(k == 7));
      chk("wb_no_awe", 64'(arr_write_en_o), 64'd0);
      hs = mem_wr_ready_i;
      @(posedge clk); #1;
      if (hs) k++;
      cyc++;
    end
    mem_wr_ready_i = 1'b0;
    chk("wb_beats", 64'(k), 64'd8);
  endtask

  // gap: 0 = back-to-back, 1 = every other cycle, 2 = random
  task automatic rd_phase(input logic [63:0] addr, input logic [2:0] way, input logic [63:0] base,
                          input int gap, input int err_beat, input int stop_after);
    int k = 0;
    int cyc = 0;
    logic hs = 1'b0;
    logic v;
    while (!hs && cyc < 50) begin
      mem_rd_req_ready_i = 1'($urandom_range(0, 1));
      mem_rd_valid_i = 1'b1;
      mem_rd_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      chk("rq_valid", 64'(mem_rd_req_valid_o), 64'd1);
      chk("rq_addr", mem_rd_addr_o, {addr[63:6], 6'b0});
      chk("rq_no_awe", 64'(arr_write_en_o), 64'd0);
      hs = mem_rd_req_ready_i;
      @(posedge clk); #1;
      cyc++;
    end
    mem_rd_req_ready_i = 1'b0;
    chk("rq_handshake", 64'(hs), 64'd1);
    cyc = 0;
    while (k < stop_after && cyc < 100) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      mem_rd_valid_i = v;
      mem_rd_data_i  = base + 64'(k);
      mem_rd_last_i  = (k == 7) || (k == err_beat);
      @(negedge clk);
      chk("rd_awe", 64'(arr_write_en_o), 64'(v));
      chk("rd_no_wr", 64'(mem_wr_valid_o), 64'd0);
      if (v) begin
        chk("rd_loc", {arr_index_o, arr_way_sel_o, arr_word_sel_o},
            {addr[11:6], way, 3'(k)});
        chk("rd_wdata", arr_wdata_o, base + 64'(k));
        chk("rd_tag", {12'd0, arr_tag_o}, {12'd0, addr[63:12]});
        chk("rd_setv", 64'(arr_set_valid_o), 64'(k == 7));
        chk("rd_be_dirty", {arr_be_o, arr_set_dirty_o}, {8'hFF, 1'b0});
        chk("rd_perr", 64'(proto_err_o), 64'(k == err_beat && k != 7));
      end else begin
        chk("rd_perr_idle", 64'(proto_err_o), 64'd0);
      end
      @(posedge clk); #1;
      if (v) k++;
      cyc++;
    end
    mem_rd_valid_i = 1'b0;
    mem_rd_last_i  = 1'b0;
    chk("rd_beats", 64'(k), 64'(stop_after));
    if (stop_after == 8) begin
      @(negedge clk);
      chk("done_pulse", 64'(done_o), 64'd1);
      chk("done_not_ready", 64'(req_ready_o), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_after", {done_o, busy_o, req_ready_o}, 64'b001);
      for (int w = 0; w < 8; w++) chk("line_data", arr_data[addr[11:6]][way][w], base + 64'(w));
      chk("line_valid", 64'(arr_valid[addr[11:6]][way]), 64'd1);
      chk("line_tag", {12'd0, arr_tag[addr[11:6]][way]}, {12'd0, addr[63:12]});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [63:0] addr;
    logic [63:0] base;
    logic [51:0] vtag;
    logic [2:0]  way;
    logic        wb;
    int          wr_snap, vset_snap;

    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_way_i = '0; req_wb_i = 1'b0;
    req_victim_tag_i = '0; mem_wr_ready_i = 1'b0; mem_rd_req_ready_i = 1'b0;
    mem_rd_valid_i = 1'b0; mem_rd_data_i = '0; mem_rd_last_i = 1'b0;

    // Preload the dirty victim at set 0x0D way 3 while the engine is held in reset.
    pl_en = 1'b1; pl_idx = 6'h0D; pl_way = 3'd3;
    for (int w = 0; w < 8; w++) begin
      pl_word = 3'(w);
      pl_data = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset");
    @(posedge clk); #1;

    // Dirty miss with writeback address 0xABC340, always-ready memory.
    addr = 64'h0000_0000_0001_2340;
    do_req(addr, 3'd3, 1'b1, 52'hABC);
    wb_phase(addr, 3'd3, 52'hABC, 100);
    rd_phase(addr, 3'd3, 64'hC0DE_0000_0000_0000, 0, -1, 8);

    // Clean miss: set 0x0D, way 5, tag 0x12.
    wr_snap = wr_cnt;
    do_req(addr, 3'd5, 1'b0, 52'h0);
    rd_phase(addr, 3'd5, 64'hD000_0000_0000_0100, 0, -1, 8);
    chk("clean_writes", 64'(wr_cnt - wr_snap), 64'd8);

    // Writeback under ~30% backpressure, victim is the line just refilled.
    addr = {$urandom, $urandom};
    addr[11:6] = 6'h0D;
    vtag = 52'h12;
    do_req(addr, 3'd5, 1'b1, vtag);
    wb_phase(addr, 3'd5, vtag, 70);
    rd_phase(addr, 3'd5, {$urandom, $urandom}, 0, -1, 8);

    // Refill with a beat every other cycle.
    addr = {$urandom, $urandom};
    addr[11:6] = 6'(($urandom_range(0, 62)));
    wr_snap = wr_cnt;
    do_req(addr, 3'd1, 1'b0, 52'h0);
    rd_phase(addr, 3'd1, {$urandom, $urandom}, 1, -1, 8);
    chk("gap_writes", 64'(wr_cnt - wr_snap), 64'd8);

    // Early last marker on beat 3.
    addr = {$urandom, $urandom};
    addr[11:6] = 6'(($urandom_range(0, 62)));
    do_req(addr, 3'd6, 1'b0, 52'h0);
    rd_phase(addr, 3'd6, {$urandom, $urandom}, 0, 3, 8);

    // Randomized misses over known lines in set 0x0D.
    for (int i = 0; i < 4; i++) begin
      addr = {$urandom, $urandom};
      addr[11:6] = 6'h0D;
      way  = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd5;
      wb   = 1'($urandom_range(0, 1));
      vtag = {20'($urandom), $urandom};
      do_req(addr, way, wb, vtag);
      if (wb) wb_phase(addr, way, vtag, 50 + 10 * i);
      rd_phase(addr, way, {$urandom, $urandom}, 2, -1, 8);
    end

    // Reset after four refill beats: abort, line stays invalid, stray beats ignored.
    addr = 64'h0000_0000_0005_6FC0;
    vset_snap = vset_cnt;
    do_req(addr, 3'd7, 1'b0, 52'h0);
    rd_phase(addr, 3'd7, 64'h5555_0000_0000_0000, 0, -1, 4);
    wr_snap = wr_cnt;
    rst_i = 1'b1;
    mem_rd_valid_i = 1'b1;
    mem_rd_data_i = 64'hFEED_FEED_FEED_FEED;
    @(negedge clk);
    chk("rst_cycle_awe", 64'(arr_write_en_o), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk_quiet("abort");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      mem_rd_last_i = (c == 2);
      @(negedge clk);
      chk("stray_awe", 64'(arr_write_en_o), 64'd0);
    end
    @(posedge clk); #1;
    mem_rd_valid_i = 1'b0;
    mem_rd_last_i  = 1'b0;
    @(negedge clk);
    chk("abort_writes", 64'(wr_cnt - wr_snap), 64'd0);
    chk("abort_vset", 64'(vset_cnt - vset_snap), 64'd0);
    chk("abort_line_invalid", 64'(arr_valid[6'h3F][7]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
